// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - shared types and constants for the platform scheduler
// Contents:
//   plat_entry_t   one platform table entry (x, y, valid, dir)
//   sched_state_t  scheduler FSM states
//   PLAT_W_*       platform widths per difficulty level
//   plat_width()   difficulty -> platform width
package doodle_pkg;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic       valid;
    logic       dir;    // 0 = moving right, 1 = moving left
  } plat_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_t;

  localparam logic [8:0] PLAT_W_EASY = 9'd64;
  localparam logic [8:0] PLAT_W_MED  = 9'd48;
  localparam logic [8:0] PLAT_W_HARD = 9'd32;

  localparam int SCREEN_H_DEFAULT = 480;

  function automatic logic [8:0] plat_width(input logic [1:0] diff);
    case (diff)
      2'd0:    plat_width = PLAT_W_EASY;
      2'd1:    plat_width = PLAT_W_MED;
      default: plat_width = PLAT_W_HARD;
    endcase
  endfunction

endpackage

// File: rtl/plat_scheduler_if.sv
// rtl/plat_scheduler_if.sv - indexed read port into the platform table
// Signals:
//   rd_idx    entry index driven by the reader (color_mapper)
//   rd_x      X of the addressed entry, one cycle later
//   rd_y      Y of the addressed entry, one cycle later
//   rd_valid  entry valid flag, 0 for indices past the table
// Modports: master = reader side, slave = table owner side.
interface plat_scheduler_if;
  logic [3:0] rd_idx;
  logic [8:0] rd_x;
  logic [8:0] rd_y;
  logic       rd_valid;

  modport master (output rd_idx, input rd_x, input rd_y, input rd_valid);
  modport slave  (input rd_idx, output rd_x, output rd_y, output rd_valid);
endinterface

// File: rtl/plat_lfsr.sv
// rtl/plat_lfsr.sv - 16-bit Galois LFSR (taps 0xB400) for platform X generation
// Ports:
//   Clk      system clock
//   Reset_n  asynchronous active-low reset (q <= SEED)
//   load     reload SEED (wins over step)
//   step     advance one position
//   q        current state, never zero for a nonzero SEED
module plat_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        load,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (step) begin
      q <= q[0] ? ((q >> 1) ^ 16'hB400) : (q >> 1);
    end
  end

endmodule

// File: rtl/plat_scheduler.sv
// rtl/plat_scheduler.sv - platform table owner, per-frame scroll/recycle sequencer, score
// Ports:
//   Clk, Reset_n   system clock, asynchronous active-low reset
//   frame_clk      VGA vsync, asynchronous; rising edge starts a frame update
//   start          single-cycle new-game pulse (re-initialises the table)
//   scroll_dy      pixels to scroll, sampled at the frame edge
//   rd             indexed read port (slave side), one-cycle latency
//   busy           FSM not idle
//   frame_done     one-cycle pulse at the end of a frame update
//   overrun        sticky: frame edge seen while busy; cleared by start
//   score          accumulated scroll, saturating at 4095
//   difficulty     0/1/2 from score thresholds
//   plat_size_x    platform width for the current difficulty
// Build option: define PLAT_MOVING_EN to make odd entries drift horizontally.
module plat_scheduler
  import doodle_pkg::*;
#(
  parameter int          NUM_PLAT  = 15,
  parameter int          SCREEN_H  = SCREEN_H_DEFAULT,
  parameter int          GAP       = 32,
  parameter int          X_MIN     = 64,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          SCORE_TH1 = 1000,
  parameter int          SCORE_TH2 = 3000
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_clk,
  input  logic             start,
  input  logic [7:0]       scroll_dy,
  plat_scheduler_if.slave  rd,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun,
  output logic [11:0]      score,
  output logic [1:0]       difficulty,
  output logic [8:0]       plat_size_x
);

  localparam logic [8:0] X_LO = 9'(X_MIN);
  localparam logic [8:0] X_HI = 9'(X_MIN + 255);

  sched_state_t state;
  logic [3:0]   idx;
  logic [7:0]   dy;
  logic [2:0]   fsync;
  logic         frame_tick;
  logic         last;

  plat_entry_t  plat_tbl [NUM_PLAT];
  plat_entry_t  cur;
  plat_entry_t  wr_entry;
  logic         wr_en;

  logic [15:0]  lfsr_q;
  logic         lfsr_step;
  logic [8:0]   new_x;
  logic [9:0]   s;
  logic [12:0]  score_sum;
  logic [11:0]  score_new;

  function automatic logic [1:0] diff_of(input logic [11:0] sc);
    if (sc < 12'(SCORE_TH1))      diff_of = 2'd0;
    else if (sc < 12'(SCORE_TH2)) diff_of = 2'd1;
    else                          diff_of = 2'd2;
  endfunction

  plat_lfsr #(.SEED(SEED)) u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .load    (start),
    .step    (lfsr_step),
    .q       (lfsr_q)
  );

  // fsync[1:0] is the synchroniser, fsync[2] the previous synchronised value
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) fsync <= 3'b000;
    else          fsync <= {fsync[1:0], frame_clk};
  end
  assign frame_tick = fsync[1] & ~fsync[2];

  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign last       = (idx == 4'(NUM_PLAT - 1));
  assign cur        = plat_tbl[idx];
  assign new_x      = X_LO + {1'b0, lfsr_q[7:0]};
  assign s          = {1'b0, cur.y} + {2'b00, dy};
  assign score_sum  = {1'b0, score} + {5'd0, dy};
  assign score_new  = score_sum[12] ? 12'hFFF : score_sum[11:0];

  // Next value of the entry at idx; start suppresses every table write
  always_comb begin
    wr_en     = 1'b0;
    wr_entry  = cur;
    lfsr_step = 1'b0;
    if (!start) begin
      case (state)
        ST_INIT: begin
          wr_en          = 1'b1;
          wr_entry.x     = new_x;
          wr_entry.y     = 9'((NUM_PLAT - 1 - int'(idx)) * GAP);
          wr_entry.valid = 1'b1;
          wr_entry.dir   = 1'b0;
          lfsr_step      = 1'b1;
        end
        ST_UPDATE: begin
          if (cur.valid) begin
            wr_en = 1'b1;
`ifdef PLAT_MOVING_EN
            // Bounce at the edges: flip direction and step back inward
            if (idx[0]) begin
              if (!cur.dir) begin
                if (cur.x == X_HI) begin
                  wr_entry.dir = 1'b1;
                  wr_entry.x   = cur.x - 9'd1;
                end else begin
                  wr_entry.x   = cur.x + 9'd1;
                end
              end else begin
                if (cur.x == X_LO) begin
                  wr_entry.dir = 1'b0;
                  wr_entry.x   = cur.x + 9'd1;
                end else begin
                  wr_entry.x   = cur.x - 9'd1;
                end
              end
            end
`endif
            if (s < 10'(SCREEN_H)) begin
              wr_entry.y = s[8:0];
            end else begin
              wr_entry.y   = 9'(s - 10'(SCREEN_H));
              wr_entry.x   = new_x;
              wr_entry.dir = 1'b0;
              lfsr_step    = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_PLAT; i++) plat_tbl[i] <= '0;
    end else if (wr_en) begin
      plat_tbl[idx] <= wr_entry;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      idx         <= 4'd0;
      dy          <= 8'd0;
      score       <= 12'd0;
      difficulty  <= 2'd0;
      plat_size_x <= PLAT_W_EASY;
      overrun     <= 1'b0;
    end else if (start) begin
      state       <= ST_INIT;
      idx         <= 4'd0;
      score       <= 12'd0;
      difficulty  <= 2'd0;
      plat_size_x <= PLAT_W_EASY;
      overrun     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            dy <= scroll_dy;
            if (scroll_dy != 8'd0) begin
              state <= ST_UPDATE;
              idx   <= 4'd0;
            end
          end
        end
        ST_INIT: begin
          if (last) begin
            state <= ST_IDLE;
            idx   <= 4'd0;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        ST_UPDATE: begin
          if (last) begin
            state <= ST_DONE;
            idx   <= 4'd0;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        ST_DONE: begin
          score       <= score_new;
          difficulty  <= diff_of(score_new);
          plat_size_x <= plat_width(diff_of(score_new));
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (frame_tick && (state != ST_IDLE)) overrun <= 1'b1;
    end
  end

  // Registered read; a same-cycle update is not visible until the next read
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd.rd_x     <= 9'd0;
      rd.rd_y     <= 9'd0;
      rd.rd_valid <= 1'b0;
    end else if (rd.rd_idx < 4'(NUM_PLAT)) begin
      rd.rd_x     <= plat_tbl[rd.rd_idx].x;
      rd.rd_y     <= plat_tbl[rd.rd_idx].y;
      rd.rd_valid <= plat_tbl[rd.rd_idx].valid;
    end else begin
      rd.rd_x     <= 9'd0;
      rd.rd_y     <= 9'd0;
      rd.rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plat_scheduler.sv
// tb/tb_plat_scheduler.sv - randomized self-checking bench for plat_scheduler
module tb_plat_scheduler;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  scroll_dy = 8'd0;
  logic        busy, frame_done, overrun;
  logic [11:0] score;
  logic [1:0]  difficulty;
  logic [8:0]  plat_size_x;

  plat_scheduler_if rd ();

  plat_scheduler dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .start       (start),
    .scroll_dy   (scroll_dy),
    .rd          (rd),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .score       (score),
    .difficulty  (difficulty),
    .plat_size_x (plat_size_x)
  );

  always #10 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  int          m_x [15];
  int          m_y [15];
  int          m_v [15];
  int          m_dir [15];
  logic [15:0] m_lfsr;
  int          m_score;
  int          m_over;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ 16'hB400) : (q >> 1);
  endfunction

  function automatic int exp_diff(input int sc);
    if (sc < 1000) return 0;
    if (sc < 3000) return 1;
    return 2;
  endfunction

  function automatic int exp_size(input int sc);
    case (exp_diff(sc))
      0:       return 64;
      1:       return 48;
      default: return 32;
    endcase
  endfunction

  task automatic m_init();
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 15; i++) begin
      m_x[i]   = 64 + int'(m_lfsr[7:0]);
      m_y[i]   = (14 - i) * 32;
      m_v[i]   = 1;
      m_dir[i] = 0;
      m_lfsr   = lfsr_next(m_lfsr);
    end
    m_score = 0;
    m_over  = 0;
  endtask

  task automatic m_frame(input int dy);
    if (dy == 0) return;
    for (int i = 0; i < 15; i++) begin
      if (m_v[i] == 0) continue;
`ifdef PLAT_MOVING_EN
      if (i % 2 == 1) begin
        if (m_dir[i] == 0) begin
          if (m_x[i] == 319) begin m_dir[i] = 1; m_x[i] = 318; end
          else m_x[i] = m_x[i] + 1;
        end else begin
          if (m_x[i] == 64) begin m_dir[i] = 0; m_x[i] = 65; end
          else m_x[i] = m_x[i] - 1;
        end
      end
`endif
      if (m_y[i] + dy < 480) begin
        m_y[i] = m_y[i] + dy;
      end else begin
        m_y[i]   = m_y[i] + dy - 480;
        m_x[i]   = 64 + int'(m_lfsr[7:0]);
        m_dir[i] = 0;
        m_lfsr   = lfsr_next(m_lfsr);
      end
    end
    m_score = (m_score + dy > 4095) ? 4095 : m_score + dy;
  endtask

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic compare_table(input string tag, input bit range_chk);
    for (int i = 0; i < 16; i++) begin
      rd.rd_idx = 4'(i);
      @(negedge Clk);
      if (i < 15) begin
        check($sformatf("%s_x%0d", tag, i), 32'(rd.rd_x), 32'(m_x[i]));
        check($sformatf("%s_y%0d", tag, i), 32'(rd.rd_y), 32'(m_y[i]));
        check($sformatf("%s_v%0d", tag, i), 32'(rd.rd_valid), 32'(m_v[i]));
        if (range_chk)
          check($sformatf("%s_xrange%0d", tag, i),
                32'(rd.rd_x >= 9'd64 && rd.rd_x <= 9'd319), 32'd1);
      end else begin
        check($sformatf("%s_x15", tag), 32'(rd.rd_x), 32'd0);
        check($sformatf("%s_y15", tag), 32'(rd.rd_y), 32'd0);
        check($sformatf("%s_v15", tag), 32'(rd.rd_valid), 32'd0);
      end
    end
    rd.rd_idx = 4'd0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_score"}, 32'(score), 32'(m_score));
    check({tag, "_diff"}, 32'(difficulty), 32'(exp_diff(m_score)));
    check({tag, "_size"}, 32'(plat_size_x), 32'(exp_size(m_score)));
    check({tag, "_overrun"}, 32'(overrun), 32'(m_over));
  endtask

  task automatic do_start(output int busy_cnt);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      busy_cnt++;
      @(negedge Clk);
    end
    m_init();
  endtask

  // One frame edge; optionally a second edge while the first update runs
  task automatic run_frame(input int dy, input bit second_edge, input string tag);
    int done_cnt, busy_cnt;
    scroll_dy = 8'(dy);
    frame_clk = 1'b1;
    done_cnt  = 0;
    busy_cnt  = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge Clk);
      if (frame_done) done_cnt++;
      if (busy) busy_cnt++;
      if (second_edge && c == 6) frame_clk = 1'b0;
      if (second_edge && c == 9) frame_clk = 1'b1;
    end
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    m_frame(dy);
    if (second_edge) m_over = 1;
    check({tag, "_done_cnt"}, 32'(done_cnt), (dy != 0) ? 32'd1 : 32'd0);
    check({tag, "_busy_cnt"}, 32'(busy_cnt), (dy != 0) ? 32'd16 : 32'd0);
    check_status(tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int bc;
    int dy;
    rd.rd_idx = 4'd0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_diff", 32'(difficulty), 32'd0);
    check("rst_size", 32'(plat_size_x), 32'd64);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_rd_x", 32'(rd.rd_x), 32'd0);
    check("rst_rd_y", 32'(rd.rd_y), 32'd0);
    check("rst_rd_valid", 32'(rd.rd_valid), 32'd0);

    // new game
    do_start(bc);
    check("init_busy_cycles", 32'(bc), 32'd15);
    compare_table("init", 1'b1);
    check_status("init");

    // first scroll, then a zero scroll
    run_frame(40, 1'b0, "dy40");
    compare_table("dy40", 1'b0);
    run_frame(0, 1'b0, "dy0");
    compare_table("dy0", 1'b0);

    // frame edge while busy
    run_frame(100, 1'b1, "overrun");
    compare_table("overrun", 1'b0);

    // randomized frames
    for (int f = 0; f < 20; f++) begin
      dy = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      run_frame(dy, 1'b0, $sformatf("rnd%0d", f));
      compare_table($sformatf("rnd%0d", f), 1'b0);
    end

    // start in the middle of an update (entry 7 in flight)
    scroll_dy = 8'd200;
    frame_clk = 1'b1;
    bc = 0;
    for (int c = 0; c < 20 && !busy; c++) begin
      bc++;
      @(negedge Clk);
    end
    check("mid_update_started", 32'(busy), 32'd1);
    repeat (7) @(negedge Clk);
    do_start(bc);
    frame_clk = 1'b0;
    check("mid_restart_busy_cycles", 32'(bc), 32'd15);
    repeat (4) @(negedge Clk);
    compare_table("restart", 1'b1);
    check_status("restart");

    // difficulty ramp and saturation
    for (int f = 1; f <= 17; f++) begin
      run_frame(255, 1'b0, $sformatf("ramp%0d", f));
    end
    check("ramp_final_score", 32'(score), 32'd4095);
    compare_table("ramp", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
